// File: rtl/iscore_pkg.sv
// Shared pixel/instrument encodings, scheduler state constants and the
// per-pixel attribute payload used by the raster scheduler.
package iscore_pkg;

  typedef enum logic [1:0] {
    PIX_NOTE  = 2'b00,
    PIX_STAFF = 2'b01,
    PIX_TEXT  = 2'b10,
    PIX_BG    = 2'b11
  } pix_type_e;

  typedef enum logic [1:0] {
    INSTR_VIOLIN   = 2'b00,
    INSTR_PIANO    = 2'b01,
    INSTR_ELECTRIC = 2'b10,
    INSTR_DEFAULT  = 2'b11
  } instr_e;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_QUERY  = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_EMIT   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef struct packed {
    pix_type_e ptype;
    instr_e    instr;
  } pix_attr_t;

endpackage

// File: rtl/raster_counter.sv
// Raster x/y position counter: clear to origin, advance in raster order,
// and flag the last active pixel. Never advances past the last pixel.
module raster_counter #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_clear,
  input  logic           i_advance,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_last
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           w_last;

  assign w_last = (r_x == X_LAST) && (r_y == Y_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_advance && !w_last) begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= r_y + Y_W'(1);
      end else begin
        r_x <= r_x + X_W'(1);
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = w_last;

endmodule

// File: rtl/pixel_type_scheduler.sv
// Raster-order scheduler: queries the note/staff/text layer generators per
// pixel, resolves layer priority and streams typed pixels over valid/ready.
module pixel_type_scheduler
  import iscore_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  output logic [X_W-1:0] qry_x,
  output logic [Y_W-1:0] qry_y,
  output logic           qry_valid,
  input  logic           note_hit,
  input  logic [1:0]     note_instr,
  input  logic           staff_hit,
  input  logic           text_hit,
  output logic           pix_valid,
  input  logic           pix_ready,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic [1:0]     pixel_type,
  output logic [1:0]     instrument_type,
  output logic           busy,
  output logic           done
);

  // Highest-priority layer wins; instrument only carried for note pixels.
  function automatic pix_attr_t resolve(input logic note, input logic [1:0] instr,
                                        input logic staff, input logic text);
    pix_attr_t a;
    a.instr = INSTR_VIOLIN;
    if (note) begin
      a.ptype = PIX_NOTE;
      a.instr = instr_e'(instr);
    end else if (staff) begin
      a.ptype = PIX_STAFF;
    end else if (text) begin
      a.ptype = PIX_TEXT;
    end else begin
      a.ptype = PIX_BG;
    end
    return a;
  endfunction

  localparam pix_attr_t ATTR_RST = '{ptype: PIX_BG, instr: INSTR_VIOLIN};

  logic [2:0]     r_state, w_state_nxt;
  logic           r_qry_valid, w_qry_valid_nxt;
  logic           r_pix_valid, w_pix_valid_nxt;
  logic [X_W-1:0] r_pix_x, w_pix_x_nxt;
  logic [Y_W-1:0] r_pix_y, w_pix_y_nxt;
  pix_attr_t      r_attr, w_attr_nxt;
  logic           r_busy, w_busy_nxt;
  logic           r_done, w_done_nxt;
  logic           w_clear, w_advance, w_last;
  logic [X_W-1:0] w_x;
  logic [Y_W-1:0] w_y;

  raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_raster (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_clear),
    .i_advance (w_advance),
    .o_x       (w_x),
    .o_y       (w_y),
    .o_last    (w_last)
  );

  // Next-state and next-output logic; abort overrides everything.
  always_comb begin
    w_state_nxt     = r_state;
    w_qry_valid_nxt = 1'b0;
    w_pix_valid_nxt = r_pix_valid;
    w_pix_x_nxt     = r_pix_x;
    w_pix_y_nxt     = r_pix_y;
    w_attr_nxt      = r_attr;
    w_done_nxt      = 1'b0;
    w_clear         = 1'b0;
    w_advance       = 1'b0;
    if (abort) begin
      w_state_nxt     = ST_IDLE;
      w_pix_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nxt     = ST_QUERY;
            w_qry_valid_nxt = 1'b1;
            w_clear         = 1'b1;
          end
        end
        ST_QUERY: w_state_nxt = ST_SAMPLE;
        ST_SAMPLE: begin
          w_state_nxt     = ST_EMIT;
          w_pix_valid_nxt = 1'b1;
          w_pix_x_nxt     = w_x;
          w_pix_y_nxt     = w_y;
          w_attr_nxt      = resolve(note_hit, note_instr, staff_hit, text_hit);
        end
        ST_EMIT: begin
          if (pix_ready) begin
            w_pix_valid_nxt = 1'b0;
            if (w_last) begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt     = ST_QUERY;
              w_qry_valid_nxt = 1'b1;
              w_advance       = 1'b1;
            end
          end
        end
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
    w_busy_nxt = (w_state_nxt == ST_QUERY) || (w_state_nxt == ST_SAMPLE) ||
                 (w_state_nxt == ST_EMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_qry_valid <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_attr      <= ATTR_RST;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_qry_valid <= w_qry_valid_nxt;
      r_pix_valid <= w_pix_valid_nxt;
      r_pix_x     <= w_pix_x_nxt;
      r_pix_y     <= w_pix_y_nxt;
      r_attr      <= w_attr_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign qry_x           = w_x;
  assign qry_y           = w_y;
  assign qry_valid       = r_qry_valid;
  assign pix_valid       = r_pix_valid;
  assign pix_x           = r_pix_x;
  assign pix_y           = r_pix_y;
  assign pixel_type      = r_attr.ptype;
  assign instrument_type = r_attr.instr;
  assign busy            = r_busy;
  assign done            = r_done;

endmodule

// File: tb/tb_pixel_type_scheduler.sv
// Scoreboard bench for pixel_type_scheduler on a 4x2 raster with random
// layer hits, random backpressure, stalls, abort and asynchronous reset.
`timescale 1ns/1ps
module tb_pixel_type_scheduler;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int NPIX = H * V;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [XW-1:0] qry_x;
  logic [YW-1:0] qry_y;
  logic          qry_valid;
  logic          note_hit = 1'b0;
  logic [1:0]    note_instr = 2'b00;
  logic          staff_hit = 1'b0;
  logic          text_hit = 1'b0;
  logic          pix_valid;
  logic          pix_ready = 1'b1;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [1:0]    pixel_type;
  logic [1:0]    instrument_type;
  logic          busy;
  logic          done;

  pixel_type_scheduler #(.H_ACTIVE(H), .V_ACTIVE(V), .X_W(XW), .Y_W(YW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .qry_x(qry_x), .qry_y(qry_y), .qry_valid(qry_valid),
    .note_hit(note_hit), .note_instr(note_instr), .staff_hit(staff_hit), .text_hit(text_hit),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pixel_type(pixel_type), .instrument_type(instrument_type), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int ptype;
    int instr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   pix_cnt = 0;
  int   done_cnt = 0;
  int   ready_mode = 0;   // 0: always ready, 1: random, 2: held low
  int   hit_mode = 0;     // 0: no hits, 1: random hits plus fixed cases on row 0

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Layer generator model: answers each query and records the expected pixel.
  initial begin : layer
    int   k;
    bit   sample_next;
    int   ex, ey;
    logic n, s, t;
    logic [1:0] ni;
    exp_t e;
    k = 0;
    sample_next = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        k = 0;
        sample_next = 0;
      end else if (start && !busy && !abort) begin
        k = 0;
      end
      if (rst_n && qry_valid) begin
        ex = k % H;
        ey = k / H;
        check("qry_x", int'(qry_x), ex);
        check("qry_y", int'(qry_y), ey);
        if (hit_mode == 0) begin
          n = 1'b0; s = 1'b0; t = 1'b0; ni = 2'($urandom);
        end else begin
          n  = ($urandom_range(0, 3) == 0);
          s  = ($urandom_range(0, 2) == 0);
          t  = ($urandom_range(0, 1) == 0);
          ni = 2'($urandom);
          if (ex == 1 && ey == 0) begin n = 1'b1; ni = 2'b10; s = 1'b1; end
          if (ex == 2 && ey == 0) begin n = 1'b0; s = 1'b1; t = 1'b0; end
          if (ex == 3 && ey == 0) begin n = 1'b0; s = 1'b0; t = 1'b1; end
        end
        note_hit = n; note_instr = ni; staff_hit = s; text_hit = t;
        e.x = ex;
        e.y = ey;
        e.ptype = n ? 0 : (s ? 1 : (t ? 2 : 3));
        e.instr = n ? int'(ni) : 0;
        sb.push_back(e);
        k++;
        sample_next = 1;
      end else if (sample_next) begin
        sample_next = 0;
      end else begin
        note_hit = 1'($urandom); note_instr = 2'($urandom);
        staff_hit = 1'($urandom); text_hit = 1'($urandom);
      end
    end
  end

  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = 1'($urandom % 2);
        default: pix_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops on each accepted pixel, checks stability while stalled.
  initial begin : monitor
    bit   stall;
    int   sx, sy, st, si;
    exp_t e;
    stall = 0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (!rst_n || abort) sb.delete();
      if (stall && rst_n) begin
        check("stall_valid", int'(pix_valid), 1);
        check("stall_x", int'(pix_x), sx);
        check("stall_y", int'(pix_y), sy);
        check("stall_type", int'(pixel_type), st);
        check("stall_instr", int'(instrument_type), si);
      end
      stall = 0;
      if (rst_n && !abort && pix_valid) begin
        if (pix_ready) begin
          pix_cnt++;
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_pixel: got (%0d,%0d) expected none", pix_x, pix_y);
          end else begin
            e = sb.pop_front();
            check("pix_x", int'(pix_x), e.x);
            check("pix_y", int'(pix_y), e.y);
            check("pixel_type", int'(pixel_type), e.ptype);
            check("instrument_type", int'(instrument_type), e.instr);
          end
        end else begin
          stall = 1;
          sx = int'(pix_x); sy = int'(pix_y);
          st = int'(pixel_type); si = int'(instrument_type);
        end
      end
    end
  end

  int base_pix, base_done;

  task automatic pulse_start();
    base_pix  = pix_cnt;
    base_done = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    int cyc;
    cyc = 0;
    while (done_cnt == base_done && cyc < 2000) begin
      tick();
      cyc++;
    end
    check({tag, "_done_seen"}, int'(done_cnt != base_done), 1);
    repeat (3) tick();
    check({tag, "_pixels"}, pix_cnt - base_pix, NPIX);
    check({tag, "_done_pulses"}, done_cnt - base_done, 1);
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  task automatic wait_pix(input string tag, input int x, input int y);
    int cyc;
    cyc = 0;
    while (!(pix_valid && int'(pix_x) == x && int'(pix_y) == y) && cyc < 500) begin
      tick();
      cyc++;
    end
    check({tag, "_reached"}, int'(pix_valid && int'(pix_x) == x && int'(pix_y) == y), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_qry_valid"}, int'(qry_valid), 0);
    check({tag, "_pix_valid"}, int'(pix_valid), 0);
    check({tag, "_pixel_type"}, int'(pixel_type), 3);
    check({tag, "_instr"}, int'(instrument_type), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pix_xy"}, int'(pix_x) + int'(pix_y), 0);
  endtask

  initial begin : main
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Plain frame with latency checks on the first pixel
    pulse_start();
    check("lat_q_valid", int'(qry_valid), 1);
    check("lat_q_busy", int'(busy), 1);
    check("lat_q_pix", int'(pix_valid), 0);
    tick();
    check("lat_s_pix", int'(pix_valid), 0);
    check("lat_s_qry", int'(qry_valid), 0);
    tick();
    check("lat_e_pix", int'(pix_valid), 1);
    finish_frame("bg_frame");

    // Random hits with random backpressure
    hit_mode = 1;
    ready_mode = 1;
    pulse_start();
    finish_frame("rand_frame");

    // Stall five cycles at (2,0)
    ready_mode = 0;
    pulse_start();
    wait_pix("stall", 2, 0);
    ready_mode = 2;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_no_qry", int'(qry_valid), 0);
      check("stall_held", int'(pix_valid), 1);
    end
    ready_mode = 0;
    finish_frame("stall_frame");

    // Start pulsed while emitting must be ignored
    ready_mode = 1;
    pulse_start();
    wait_pix("busy_start", 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_frame("busy_start_frame");

    // Abort at (1,1), then restart
    ready_mode = 0;
    pulse_start();
    wait_pix("abort", 1, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_pix_valid", int'(pix_valid), 0);
    check("abort_qry_valid", int'(qry_valid), 0);
    check("abort_busy", int'(busy), 0);
    repeat (6) tick();
    check("abort_no_done", done_cnt - base_done, 0);
    check("abort_stays_idle", int'(busy), 0);
    ready_mode = 1;
    pulse_start();
    finish_frame("after_abort");

    // Asynchronous reset mid-frame, then a full frame
    pulse_start();
    repeat (7) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    finish_frame("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
